prbs5_checker: RTL and testbench



---
 rtl/prbs5_checker.sv | 159 +++++++++++++++
 tb/tb_prbs5_checker.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs5_checker.sv
// prbs5_checker: self-synchronising checker for the PRBS-5 recurrence
// r[n] = r[n-5] ^ r[n-3]. Hunts, syncs on consecutive matches, then flywheels
// its own history while locked so received errors never corrupt the prediction.
module prbs5_checker #(
  parameter int LOCK_THRESH = 8,
  parameter int UNLOCK_ERRS = 4,
  parameter int WINDOW      = 31,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             err_clr,
  output logic             locked,
  output logic             bit_err,
  output logic [CNT_W-1:0] err_count,
  output logic             lock_lost
);

  localparam int MW = $clog2(LOCK_THRESH + 1);
  localparam int WW = $clog2(WINDOW + 1);
  localparam int EW = $clog2(UNLOCK_ERRS + 1);

  localparam logic [MW-1:0] LT_M1  = MW'(LOCK_THRESH - 1);
  localparam logic [WW-1:0] WIN_M1 = WW'(WINDOW - 1);
  localparam logic [EW-1:0] UE_M1  = EW'(UNLOCK_ERRS - 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       h_q, h_d;          // h[0] oldest, h[4] newest
  logic [2:0]       fill_q, fill_d;
  logic [MW-1:0]    match_q, match_d;
  logic [WW-1:0]    win_cnt_q, win_cnt_d;
  logic [EW-1:0]    win_errs_q, win_errs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             locked_q, locked_d;
  logic             bit_err_q, bit_err_d;
  logic             lock_lost_q, lock_lost_d;

  logic pred;
  logic mism;

  assign pred = h_q[0] ^ h_q[2];
  assign mism = (bit_in != pred);

  // State and output registers; reset returns to HUNT with everything cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= HUNT;
      h_q         <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      win_cnt_q   <= '0;
      win_errs_q  <= '0;
      cnt_q       <= '0;
      locked_q    <= 1'b0;
      bit_err_q   <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      win_cnt_q   <= win_cnt_d;
      win_errs_q  <= win_errs_d;
      cnt_q       <= cnt_d;
      locked_q    <= locked_d;
      bit_err_q   <= bit_err_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  // Next-state logic: only valid bits advance anything; err_clr acts every cycle
  // and is applied before a same-cycle error increment.
  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    fill_d      = fill_q;
    match_d     = match_q;
    win_cnt_d   = win_cnt_q;
    win_errs_d  = win_errs_q;
    cnt_d       = err_clr ? '0 : cnt_q;
    bit_err_d   = 1'b0;
    lock_lost_d = 1'b0;

    if (bit_valid) begin
      unique case (state_q)
        HUNT: begin
          h_d    = {bit_in, h_q[4:1]};
          fill_d = fill_q + 1'b1;
          if (fill_q == 3'd4) begin
            state_d = SYNC;
            match_d = '0;
          end
        end

        SYNC: begin
          h_d = {bit_in, h_q[4:1]};
          // An all-zero history predicts 0 forever; refusing to count those
          // matches keeps a stuck-at-0 line from ever locking.
          if (!mism && (h_q != 5'd0)) begin
            match_d = match_q + 1'b1;
            if (match_q == LT_M1) begin
              state_d    = LOCKED;
              win_cnt_d  = '0;
              win_errs_d = '0;
            end
          end else begin
            match_d = '0;
          end
        end

        LOCKED: begin
          // Flywheel: shift in the prediction, not the received bit.
          h_d = {pred, h_q[4:1]};
          if (mism) begin
            bit_err_d = 1'b1;
            if (cnt_d != {CNT_W{1'b1}}) begin
              cnt_d = cnt_d + 1'b1;
            end
          end
          if (mism && (win_errs_q == UE_M1)) begin
            state_d     = HUNT;
            lock_lost_d = 1'b1;
            fill_d      = '0;
            win_cnt_d   = '0;
            win_errs_d  = '0;
          end else if (win_cnt_q == WIN_M1) begin
            win_cnt_d  = '0;
            win_errs_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + 1'b1;
            if (mism) begin
              win_errs_d = win_errs_q + 1'b1;
            end
          end
        end

        default: begin
          state_d = HUNT;
        end
      endcase
    end

    locked_d = (state_d == LOCKED);
  end

  assign locked    = locked_q;
  assign bit_err   = bit_err_q;
  assign err_count = cnt_q;
  assign lock_lost = lock_lost_q;

endmodule

// File: tb/tb_prbs5_checker.sv
// Testbench for prbs5_checker: directed scenarios plus a random soak, every
// cycle compared against a queue-based reference model of the PRBS-5 checker.
module tb_prbs5_checker;
  localparam int CW  = 4;
  localparam int LT  = 8;
  localparam int UE  = 4;
  localparam int WIN = 31;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          bit_valid = 1'b0;
  logic          bit_in = 1'b0;
  logic          err_clr = 1'b0;
  logic          locked;
  logic          bit_err;
  logic          lock_lost;
  logic [CW-1:0] err_count;

  always #5 clk = ~clk;

  prbs5_checker #(
    .LOCK_THRESH(LT), .UNLOCK_ERRS(UE), .WINDOW(WIN), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .bit_valid(bit_valid), .bit_in(bit_in),
    .err_clr(err_clr), .locked(locked), .bit_err(bit_err),
    .err_count(err_count), .lock_lost(lock_lost)
  );

  int total = 0;
  int bad = 0;

  // One period of the generator stream from seed 5'h01.
  bit seq[31];
  int gidx;

  // Reference model state
  int m_state;          // 0 hunt, 1 sync, 2 locked
  bit hist[$];          // oldest first
  int m_fill, m_match, m_wpos, m_werr, m_cnt;
  bit m_locked, m_bit_err, m_lock_lost;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    hist = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    m_fill = 0; m_match = 0; m_wpos = 0; m_werr = 0; m_cnt = 0;
    m_locked = 0; m_bit_err = 0; m_lock_lost = 0;
  endtask

  task automatic push(input bit x);
    hist.push_back(x);
    void'(hist.pop_front());
  endtask

  task automatic model_step(input bit v, input bit b, input bit clr);
    bit p;
    bit nz;
    m_bit_err = 0;
    m_lock_lost = 0;
    if (clr) m_cnt = 0;
    if (v) begin
      p  = hist[0] ^ hist[2];
      nz = hist[0] | hist[1] | hist[2] | hist[3] | hist[4];
      if (m_state == 0) begin
        push(b);
        m_fill++;
        if (m_fill == 5) begin m_state = 1; m_match = 0; end
      end else if (m_state == 1) begin
        if (b == p && nz) m_match++; else m_match = 0;
        push(b);
        if (m_match == LT) begin m_state = 2; m_wpos = 0; m_werr = 0; end
      end else begin
        push(p);
        if (b != p) begin
          m_bit_err = 1;
          m_werr++;
          if (m_cnt < (1 << CW) - 1) m_cnt++;
        end
        m_wpos++;
        if (m_werr == UE) begin
          m_state = 0; m_lock_lost = 1; m_fill = 0;
        end else if (m_wpos == WIN) begin
          m_wpos = 0; m_werr = 0;
        end
      end
    end
    m_locked = (m_state == 2);
  endtask

  task automatic tick(input bit v, input bit b, input bit clr);
    bit_valid = v;
    bit_in    = b;
    err_clr   = clr;
    @(posedge clk);
    model_step(v, b, clr);
    #1;
    chk("m_locked", 32'(locked), 32'(m_locked));
    chk("m_bit_err", 32'(bit_err), 32'(m_bit_err));
    chk("m_lock_lost", 32'(lock_lost), 32'(m_lock_lost));
    chk("m_err_count", 32'(err_count), 32'(m_cnt));
    $display("cyc v=%0d b=%0d clr=%0d locked=%0d bit_err=%0d lock_lost=%0d err_count=%0d",
             v, b, clr, locked, bit_err, lock_lost, err_count);
  endtask

  task automatic send(input bit inv, input bit clr);
    bit bb;
    bb = seq[gidx % 31] ^ inv;
    gidx++;
    tick(1'b1, bb, clr);
  endtask

  task automatic idle();
    tick(1'b0, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bit_valid = 1'b0;
    err_clr = 1'b0;
    #2;
    model_reset();
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_bit_err", 32'(bit_err), 32'd0);
    chk("rst_lock_lost", 32'(lock_lost), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    gidx = 0;
  endtask

  task automatic lock13(input bit gapped);
    for (int i = 0; i < 13; i++) begin
      if (gapped) idle();
      if (i == 12) chk("lock_early", 32'(locked), 32'd0);
      send(1'b0, 1'b0);
    end
    chk("lock_at13", 32'(locked), 32'd1);
  endtask

  initial begin
    int pulses;
    int hi;
    int gap;
    seq[0] = 1'b1;
    for (int n = 1; n < 5; n++) seq[n] = 1'b0;
    for (int n = 5; n < 31; n++) seq[n] = seq[n-5] ^ seq[n-3];
    model_reset();
    #1;

    // Clean lock and 1000 clean bits
    do_reset();
    lock13(1'b0);
    pulses = 0;
    repeat (1000) begin
      send(1'b0, 1'b0);
      pulses += int'(bit_err);
    end
    chk("clean_pulses", 32'(pulses), 32'd0);
    chk("clean_count", 32'(err_count), 32'd0);

    // Single error: flywheel keeps lock
    repeat ($urandom_range(0, 10)) send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    chk("single_pulse", 32'(bit_err), 32'd1);
    send(1'b0, 1'b0);
    chk("single_pulse_end", 32'(bit_err), 32'd0);
    repeat (40) send(1'b0, 1'b0);
    chk("single_locked", 32'(locked), 32'd1);
    chk("single_count", 32'(err_count), 32'd1);

    // Unlock after 4 errors inside one window, then relock
    do_reset();
    lock13(1'b0);
    for (int k = 0; k < 4; k++) begin
      send(1'b1, 1'b0);
      if (k < 3) begin
        chk("unlock_hold", 32'(locked), 32'd1);
        repeat ($urandom_range(0, 3)) begin
          if ($urandom_range(0, 1) == 1) idle();
          send(1'b0, 1'b0);
        end
      end
    end
    chk("unlock_lost", 32'(lock_lost), 32'd1);
    chk("unlock_locked", 32'(locked), 32'd0);
    lock13(1'b0);

    // Window expiry: 3 errors, gap > window, 3 errors
    do_reset();
    lock13(1'b0);
    repeat (3) send(1'b1, 1'b0);
    gap = $urandom_range(32, 45);
    repeat (gap) send(1'b0, 1'b0);
    repeat (3) send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    chk("win_locked", 32'(locked), 32'd1);
    chk("win_count", 32'(err_count), 32'd6);

    // Stuck-at-0 from reset
    do_reset();
    hi = 0;
    repeat (200) begin
      tick(1'b1, 1'b0, 1'b0);
      hi += int'(locked);
    end
    chk("stuck0_never", 32'(hi), 32'd0);

    // Gapped input locks on valid-bit count
    do_reset();
    lock13(1'b1);
    repeat (50) begin
      if ($urandom_range(0, 1) == 1) idle();
      send(1'b0, 1'b0);
    end
    chk("gap_locked", 32'(locked), 32'd1);

    // Saturation at 15, then clear, then clear+error in one cycle
    do_reset();
    for (int r = 1; r <= 5; r++) begin
      lock13(1'b0);
      repeat (4) send(1'b1, 1'b0);
      chk("sat_count", 32'(err_count), 32'((4 * r > 15) ? 15 : 4 * r));
      chk("sat_unlocked", 32'(locked), 32'd0);
    end
    tick(1'b0, 1'b0, 1'b1);
    chk("clr_count", 32'(err_count), 32'd0);
    lock13(1'b0);
    send(1'b1, 1'b1);
    chk("clr_err_count", 32'(err_count), 32'd1);
    chk("clr_err_pulse", 32'(bit_err), 32'd1);

    // Random soak against the model
    do_reset();
    repeat (600) begin
      if ($urandom_range(0, 3) == 0) idle();
      else send(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 63) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
